// File: rtl/game_timebase.sv
// game_timebase
//   Paces the enemy spawner and mover with single-cycle spawn/advance strobes.
//   Periods shrink with level, turbo divides them, and an optional ice freeze
//   pauses everything for a fixed time.
//
//   Optional feature macro: GAME_TIMEBASE_ICE_EN (FREEZE state, ice timer,
//   frozen output). Without it, ice is ignored and frozen is tied low.
//
// Ports
//   clk       in   system clock
//   resetN    in   synchronous active-low reset
//   run       in   game running; low pauses the block
//   new_game  in   one-cycle pulse; clears level and counters, forces IDLE
//   turbo     in   level-sensitive fast mode
//   ice       in   one-cycle pulse; starts or restarts a freeze
//   spawn     out  one-cycle spawn strobe
//   advance   out  one-cycle advance strobe
//   lvl       out  current level (saturating)
//   frozen    out  high while in FREEZE
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_IDLE   | paused or after new_game; counters, level held, no strobes
// S_RUN    | period counters advance, strobes issued
// S_FREEZE | ice timer running; counters and level held, no strobes

module game_timebase #(
   parameter int CNT_W          = 16,
   parameter int LVL_W          = 4,
   parameter int SPAWN_PERIOD   = 512,
   parameter int ADVANCE_PERIOD = 64,
   parameter int SPAWN_STEP     = 32,
   parameter int ADVANCE_STEP   = 4,
   parameter int MIN_PERIOD     = 8,
   parameter int TURBO_SHIFT    = 2,
   parameter int SPAWNS_PER_LVL = 16,
   parameter int ICE_CYCLES     = 1024
) (
   input  logic             clk,
   input  logic             resetN,
   input  logic             run,
   input  logic             new_game,
   input  logic             turbo,
   input  logic             ice,
   output logic             spawn,
   output logic             advance,
   output logic [LVL_W-1:0] lvl,
   output logic             frozen
);

   localparam int PW      = CNT_W + LVL_W;
   localparam int TALLY_W = (SPAWNS_PER_LVL > 1) ? $clog2(SPAWNS_PER_LVL) : 1;
   localparam int ICE_W   = $clog2(ICE_CYCLES + 1);
   localparam logic [LVL_W-1:0] LVL_MAX = '1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_FREEZE = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CNT_W-1:0]   r_spawn_cnt;
   logic [CNT_W-1:0]   r_adv_cnt;
   logic [TALLY_W-1:0] r_tally;
   logic [LVL_W-1:0]   r_lvl;
   logic               r_spawn;
   logic               r_advance;
   logic [PW-1:0]      w_spawn_p;
   logic [PW-1:0]      w_adv_p;
   logic               w_spawn_hit;
   logic               w_adv_hit;
   logic               w_count_en;
   logic               w_ice_go;

   // Reduction is done in the wide domain and floored at zero before the
   // MIN_PERIOD clamp, so a large level never wraps into a huge period.
   function automatic logic [PW-1:0] f_period(input logic [PW-1:0]    i_base,
                                              input logic [PW-1:0]    i_step,
                                              input logic [LVL_W-1:0] i_lvl,
                                              input logic             i_turbo);
      logic [PW-1:0] w_red;
      logic [PW-1:0] w_p;
      w_red = PW'(i_lvl) * i_step;
      w_p   = (i_base > w_red) ? (i_base - w_red) : '0;
      if (w_p < PW'(MIN_PERIOD)) w_p = PW'(MIN_PERIOD);
      if (i_turbo) w_p = w_p >> TURBO_SHIFT;
      if (w_p == '0) w_p = PW'(1);
      return w_p;
   endfunction

   assign w_spawn_p   = f_period(PW'(SPAWN_PERIOD), PW'(SPAWN_STEP), r_lvl, turbo);
   assign w_adv_p     = f_period(PW'(ADVANCE_PERIOD), PW'(ADVANCE_STEP), r_lvl, turbo);

   // >= rather than == so a period that shrinks mid-count fires at once.
   assign w_spawn_hit = PW'(r_spawn_cnt) >= (w_spawn_p - PW'(1));
   assign w_adv_hit   = PW'(r_adv_cnt) >= (w_adv_p - PW'(1));

   // Count only in RUN cycles that stay in RUN: a cycle that leaves RUN
   // (run low, ice, new_game) must not register a strobe that would then
   // appear while paused or frozen.
   assign w_count_en  = (r_state == S_RUN) && (w_state_nxt == S_RUN);

`ifdef GAME_TIMEBASE_ICE_EN
   logic [ICE_W-1:0] r_ice_tmr;
   logic             r_frozen;

   assign w_ice_go = ice;
   assign frozen   = r_frozen;
`else
   logic [ICE_W:0] w_unused_ice;

   assign w_ice_go     = 1'b0;
   assign frozen       = 1'b0;
   assign w_unused_ice = {ice, ICE_W'(ICE_CYCLES - 1)};
`endif

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (run) w_state_nxt = S_RUN;
         end
         S_RUN: begin
            if (!run)          w_state_nxt = S_IDLE;
            else if (w_ice_go) w_state_nxt = S_FREEZE;
         end
`ifdef GAME_TIMEBASE_ICE_EN
         S_FREEZE: begin
            if (!run)                         w_state_nxt = S_IDLE;
            else if (!ice && r_ice_tmr == '0) w_state_nxt = S_RUN;
         end
`endif
         default: w_state_nxt = S_IDLE;
      endcase
      if (new_game) w_state_nxt = S_IDLE;
   end

   always_ff @(posedge clk) begin
      if (!resetN) begin
         r_state     <= S_IDLE;
         r_spawn     <= 1'b0;
         r_advance   <= 1'b0;
         r_lvl       <= '0;
         r_tally     <= '0;
         r_spawn_cnt <= '0;
         r_adv_cnt   <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_spawn   <= w_count_en && w_spawn_hit;
         r_advance <= w_count_en && w_adv_hit;
         if (new_game) begin
            r_lvl       <= '0;
            r_tally     <= '0;
            r_spawn_cnt <= '0;
            r_adv_cnt   <= '0;
         end else begin
            if (w_count_en) begin
               r_spawn_cnt <= w_spawn_hit ? '0 : r_spawn_cnt + CNT_W'(1);
               r_adv_cnt   <= w_adv_hit ? '0 : r_adv_cnt + CNT_W'(1);
            end
            // Tally on the registered strobe so lvl moves the cycle after it.
            if (r_spawn) begin
               if (r_tally == TALLY_W'(SPAWNS_PER_LVL - 1)) begin
                  r_tally <= '0;
                  if (r_lvl != LVL_MAX) r_lvl <= r_lvl + LVL_W'(1);
               end else begin
                  r_tally <= r_tally + TALLY_W'(1);
               end
            end
         end
      end
   end

`ifdef GAME_TIMEBASE_ICE_EN
   // Loaded with ICE_CYCLES-1 so FREEZE lasts ICE_CYCLES cycles including
   // the terminal-count cycle.
   always_ff @(posedge clk) begin
      if (!resetN) begin
         r_ice_tmr <= '0;
         r_frozen  <= 1'b0;
      end else begin
         r_frozen <= (w_state_nxt == S_FREEZE);
         if (new_game || w_state_nxt != S_FREEZE) r_ice_tmr <= '0;
         else if (ice)                            r_ice_tmr <= ICE_W'(ICE_CYCLES - 1);
         else if (r_ice_tmr != '0)                r_ice_tmr <= r_ice_tmr - ICE_W'(1);
      end
   end
`endif

   assign spawn   = r_spawn;
   assign advance = r_advance;
   assign lvl     = r_lvl;

endmodule
